// File: rtl/biriscv_fetch_redirect_ctrl_pkg.sv
// Shared types for the fetch redirect controller.
// Privilege encodings, FSM states and redirect source indices.
package biriscv_fetch_redirect_ctrl_pkg;

  localparam logic [1:0] PRIV_USER    = 2'd0;
  localparam logic [1:0] PRIV_SUPER   = 2'd1;
  localparam logic [1:0] PRIV_MACHINE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FLUSH = 2'd1,
    ST_REDIRECT   = 2'd2
  } state_e;

  // Lower value wins; also the bit index in the winner one-hot.
  typedef enum logic [1:0] {
    SRC_EXC     = 2'd0,
    SRC_MISPRED = 2'd1,
    SRC_FENCEI  = 2'd2
  } src_e;

  localparam int SRC_N = 3;

endpackage

// File: rtl/biriscv_fetch_redirect_ctrl_arb.sv
// Fixed-priority redirect select: exception > mispredict > FENCE.I.
// Purely combinational; produces a winner one-hot with its PC/priv.
module biriscv_redirect_arb
  import biriscv_fetch_redirect_ctrl_pkg::*;
(
  input  logic             exc_i,
  input  logic [31:0]      exc_pc_i,
  input  logic [1:0]       exc_priv_i,
  input  logic             mispred_i,
  input  logic [31:0]      mispred_pc_i,
  input  logic             fencei_i,
  input  logic [31:0]      fencei_pc_i,
  input  logic [1:0]       cur_priv_i,
  output logic [SRC_N-1:0] win_o,
  output logic [31:0]      pc_o,
  output logic [1:0]       priv_o
);

  always_comb begin
    win_o  = '0;
    pc_o   = '0;
    priv_o = cur_priv_i;
    if (exc_i) begin
      win_o[SRC_EXC] = 1'b1;
      pc_o           = exc_pc_i;
      priv_o         = exc_priv_i;
    end else if (mispred_i) begin
      win_o[SRC_MISPRED] = 1'b1;
      pc_o               = mispred_pc_i;
    end else if (fencei_i) begin
      win_o[SRC_FENCEI] = 1'b1;
      pc_o              = fencei_pc_i;
    end
  end

endmodule

// File: rtl/biriscv_fetch_redirect_ctrl.sv
// Front-end redirect sequencer: trap/mispredict/FENCE.I into fetch.
// Optional BIRISCV_REDIRECT_STATS_EN adds saturating source counters.
module biriscv_fetch_redirect_ctrl
  import biriscv_fetch_redirect_ctrl_pkg::*;
#(
  parameter int FLUSH_TIMEOUT = 255,
  parameter int TIMEOUT_W     = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        exc_redirect_i,
  input  logic [31:0] exc_pc_i,
  input  logic [1:0]  exc_priv_i,
  input  logic        mispred_i,
  input  logic [31:0] mispred_pc_i,
  input  logic        fencei_i,
  input  logic [31:0] fencei_pc_i,
  input  logic [1:0]  cur_priv_i,
  input  logic        icache_flush_done_i,
  output logic        branch_request_o,
  output logic [31:0] branch_pc_o,
  output logic [1:0]  branch_priv_o,
  output logic        fetch_invalidate_o,
  output logic        hold_flag_o,
  output logic        busy_o,
  output logic        flush_timeout_o
`ifdef BIRISCV_REDIRECT_STATS_EN
  ,
  output logic [31:0] stat_exc_o,
  output logic [31:0] stat_mispred_o,
  output logic [31:0] stat_fencei_o
`endif
);

  state_e                 state_q, state_d;
  logic [31:0]            pend_pc_q, pend_pc_d;
  logic [1:0]             pend_priv_q, pend_priv_d;
  logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;

  logic        req_q, req_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  priv_q, priv_d;
  logic        inval_q, inval_d;
  logic        hold_q, hold_d;
  logic        busy_q, busy_d;
  logic        tmo_q, tmo_d;

  logic [SRC_N-1:0] win;
  logic [31:0]      arb_pc;
  logic [1:0]       arb_priv;
  logic             arb_phase;
  logic             tmo_hit;
  logic             flush_end;

  biriscv_redirect_arb u_arb (
    .exc_i        (exc_redirect_i),
    .exc_pc_i     (exc_pc_i),
    .exc_priv_i   (exc_priv_i),
    .mispred_i    (mispred_i),
    .mispred_pc_i (mispred_pc_i),
    .fencei_i     (fencei_i),
    .fencei_pc_i  (fencei_pc_i),
    .cur_priv_i   (cur_priv_i),
    .win_o        (win),
    .pc_o         (arb_pc),
    .priv_o       (arb_priv)
  );

  // REDIRECT accepts new requests exactly like IDLE.
  assign arb_phase = (state_q == ST_IDLE) || (state_q == ST_REDIRECT);
  assign tmo_hit   = cnt_q == TIMEOUT_W'(FLUSH_TIMEOUT - 1);
  assign flush_end = icache_flush_done_i || tmo_hit;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      pend_pc_q   <= '0;
      pend_priv_q <= PRIV_MACHINE;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      pc_q        <= '0;
      priv_q      <= PRIV_MACHINE;
      inval_q     <= 1'b0;
      hold_q      <= 1'b0;
      busy_q      <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_pc_q   <= pend_pc_d;
      pend_priv_q <= pend_priv_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      pc_q        <= pc_d;
      priv_q      <= priv_d;
      inval_q     <= inval_d;
      hold_q      <= hold_d;
      busy_q      <= busy_d;
      tmo_q       <= tmo_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pend_pc_d   = pend_pc_q;
    pend_priv_d = pend_priv_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      ST_IDLE, ST_REDIRECT: begin
        state_d = ST_IDLE;
        if (win[SRC_FENCEI]) begin
          state_d     = ST_WAIT_FLUSH;
          pend_pc_d   = fencei_pc_i;
          pend_priv_d = cur_priv_i;
          cnt_d       = '0;
        end
      end
      ST_WAIT_FLUSH: begin
        cnt_d = cnt_q + 1'b1;
        if (exc_redirect_i) begin
          pend_pc_d   = exc_pc_i;
          pend_priv_d = exc_priv_i;
        end
        if (flush_end) state_d = ST_REDIRECT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_d   = 1'b0;
    pc_d    = '0;
    priv_d  = priv_q;
    inval_d = 1'b0;
    hold_d  = 1'b0;
    tmo_d   = 1'b0;
    if (arb_phase) begin
      if (win[SRC_EXC] || win[SRC_MISPRED]) begin
        req_d  = 1'b1;
        pc_d   = arb_pc;
        priv_d = arb_priv;
      end else if (win[SRC_FENCEI]) begin
        inval_d = 1'b1;
        hold_d  = 1'b1;
      end
    end else if (state_q == ST_WAIT_FLUSH) begin
      hold_d = 1'b1;
      if (flush_end) begin
        req_d  = 1'b1;
        hold_d = 1'b0;
        tmo_d  = tmo_hit && !icache_flush_done_i;
        pc_d   = exc_redirect_i ? exc_pc_i : pend_pc_q;
        priv_d = exc_redirect_i ? exc_priv_i : pend_priv_q;
      end
    end
    busy_d = state_d != ST_IDLE;
  end

  assign branch_request_o   = req_q;
  assign branch_pc_o        = pc_q;
  assign branch_priv_o      = priv_q;
  assign fetch_invalidate_o = inval_q;
  assign hold_flag_o        = hold_q;
  assign busy_o             = busy_q;
  assign flush_timeout_o    = tmo_q;

`ifdef BIRISCV_REDIRECT_STATS_EN
  logic [31:0] st_exc_q, st_mis_q, st_fen_q;
  logic        fen_done;

  assign fen_done = (state_q == ST_WAIT_FLUSH) && flush_end;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_exc_q <= '0;
      st_mis_q <= '0;
      st_fen_q <= '0;
    end else begin
      if (arb_phase && win[SRC_EXC] && st_exc_q != '1)
        st_exc_q <= st_exc_q + 1'b1;
      if (arb_phase && win[SRC_MISPRED] && st_mis_q != '1)
        st_mis_q <= st_mis_q + 1'b1;
      if (fen_done && st_fen_q != '1)
        st_fen_q <= st_fen_q + 1'b1;
    end
  end

  assign stat_exc_o     = st_exc_q;
  assign stat_mispred_o = st_mis_q;
  assign stat_fencei_o  = st_fen_q;
`endif

endmodule

// File: tb/tb_biriscv_fetch_redirect_ctrl.sv
// Scoreboard bench for the fetch redirect controller.
// Expected output vectors are queued per driven cycle, then compared.
module tb_biriscv_fetch_redirect_ctrl;

  typedef logic [38:0] ov_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc;
  logic [31:0] exc_pc;
  logic [1:0]  exc_priv;
  logic        mis;
  logic [31:0] mis_pc;
  logic        fen;
  logic [31:0] fen_pc;
  logic [1:0]  cur_priv;
  logic        done;
  logic        req;
  logic [31:0] bpc;
  logic [1:0]  bpriv;
  logic        inval;
  logic        hold;
  logic        busy;
  logic        tmo;
`ifdef BIRISCV_REDIRECT_STATS_EN
  logic [31:0] s_exc, s_mis, s_fen;
`endif

  int checks = 0;
  int errors = 0;
  ov_t exp_q[$];
  ov_t obs_q[$];

  always #5 clk = ~clk;

  biriscv_fetch_redirect_ctrl #(
    .FLUSH_TIMEOUT (8),
    .TIMEOUT_W     (16)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .exc_redirect_i      (exc),
    .exc_pc_i            (exc_pc),
    .exc_priv_i          (exc_priv),
    .mispred_i           (mis),
    .mispred_pc_i        (mis_pc),
    .fencei_i            (fen),
    .fencei_pc_i         (fen_pc),
    .cur_priv_i          (cur_priv),
    .icache_flush_done_i (done),
    .branch_request_o    (req),
    .branch_pc_o         (bpc),
    .branch_priv_o       (bpriv),
    .fetch_invalidate_o  (inval),
    .hold_flag_o         (hold),
    .busy_o              (busy),
    .flush_timeout_o     (tmo)
`ifdef BIRISCV_REDIRECT_STATS_EN
    ,
    .stat_exc_o          (s_exc),
    .stat_mispred_o      (s_mis),
    .stat_fencei_o       (s_fen)
`endif
  );

  function automatic ov_t ev(
    input logic r, input logic [31:0] pc, input logic [1:0] pv,
    input logic iv, input logic h, input logic b, input logic t);
    return {r, pc, pv, iv, h, b, t};
  endfunction

  task automatic drv(
    input logic r, input logic e, input logic [31:0] epc,
    input logic [1:0] epv, input logic m, input logic [31:0] mpc,
    input logic f, input logic [31:0] fpc, input logic d);
    rst = r; exc = e; exc_pc = epc; exc_priv = epv;
    mis = m; mis_pc = mpc; fen = f; fen_pc = fpc; done = d;
    @(posedge clk);
    #1;
    obs_q.push_back({req, bpc, bpriv, inval, hold, busy, tmo});
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    ov_t e, o;
    int i = 0;
    repeat (3) begin
      drv(1, 1, 32'h8000_0100, 3, 1, 32'h1234, 1, 32'h200, 1);
      exp_q.push_back(ev(0, 0, 3, 0, 0, 0, 0));
    end
    idle(); exp_q.push_back(ev(0, 0, 3, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset[%0d]: got %h expected %h", i, o, e);
      end
      i++;
    end
  endtask

  task automatic test_simultaneous();
    ov_t e, o;
    int i = 0;
    drv(0, 1, 32'h8000_0100, 3, 1, 32'h1234, 1, 32'h200, 0);
    exp_q.push_back(ev(1, 32'h8000_0100, 3, 0, 0, 0, 0));
    idle(); exp_q.push_back(ev(0, 0, 3, 0, 0, 0, 0));
    drv(0, 0, 0, 0, 1, 32'h1234, 1, 32'h600, 0);
    exp_q.push_back(ev(1, 32'h1234, 1, 0, 0, 0, 0));
    idle(); exp_q.push_back(ev(0, 0, 1, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL simultaneous[%0d]: got %h expected %h", i, o, e);
      end
      i++;
    end
  endtask

  task automatic test_fencei();
    ov_t e, o;
    int i = 0;
    drv(0, 0, 0, 0, 0, 0, 1, 32'h200, 0);
    exp_q.push_back(ev(0, 0, 1, 1, 1, 1, 0));
    repeat (4) begin
      idle(); exp_q.push_back(ev(0, 0, 1, 0, 1, 1, 0));
    end
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
    exp_q.push_back(ev(1, 32'h200, 1, 0, 0, 1, 0));
    idle(); exp_q.push_back(ev(0, 0, 1, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL fencei[%0d]: got %h expected %h", i, o, e);
      end
      i++;
    end
  endtask

  task automatic test_exc_in_flush();
    ov_t e, o;
    int i = 0;
    drv(0, 0, 0, 0, 0, 0, 1, 32'h200, 0);
    exp_q.push_back(ev(0, 0, 1, 1, 1, 1, 0));
    idle(); exp_q.push_back(ev(0, 0, 1, 0, 1, 1, 0));
    drv(0, 1, 32'h8000_0004, 3, 0, 0, 0, 0, 0);
    exp_q.push_back(ev(0, 0, 1, 0, 1, 1, 0));
    drv(0, 0, 0, 0, 1, 32'h1234, 0, 0, 0);
    exp_q.push_back(ev(0, 0, 1, 0, 1, 1, 0));
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
    exp_q.push_back(ev(1, 32'h8000_0004, 3, 0, 0, 1, 0));
    idle(); exp_q.push_back(ev(0, 0, 3, 0, 0, 0, 0));
    drv(0, 0, 0, 0, 0, 0, 1, 32'h300, 0);
    exp_q.push_back(ev(0, 0, 3, 1, 1, 1, 0));
    drv(0, 1, 32'h8000_0040, 0, 0, 0, 0, 0, 1);
    exp_q.push_back(ev(1, 32'h8000_0040, 0, 0, 0, 1, 0));
    idle(); exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL exc_in_flush[%0d]: got %h expected %h", i, o, e);
      end
      i++;
    end
  endtask

  task automatic test_back_to_back();
    ov_t e, o;
    int i = 0;
    drv(0, 0, 0, 0, 0, 0, 1, 32'h200, 0);
    exp_q.push_back(ev(0, 0, 0, 1, 1, 1, 0));
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
    exp_q.push_back(ev(1, 32'h200, 1, 0, 0, 1, 0));
    drv(0, 0, 0, 0, 1, 32'h444, 0, 0, 0);
    exp_q.push_back(ev(1, 32'h444, 1, 0, 0, 0, 0));
    drv(0, 0, 0, 0, 0, 0, 1, 32'h700, 0);
    exp_q.push_back(ev(0, 0, 1, 1, 1, 1, 0));
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
    exp_q.push_back(ev(1, 32'h700, 1, 0, 0, 1, 0));
    drv(0, 0, 0, 0, 0, 0, 1, 32'h800, 0);
    exp_q.push_back(ev(0, 0, 1, 1, 1, 1, 0));
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
    exp_q.push_back(ev(1, 32'h800, 1, 0, 0, 1, 0));
    idle(); exp_q.push_back(ev(0, 0, 1, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got %h expected %h", i, o, e);
      end
      i++;
    end
  endtask

  task automatic test_timeout();
    ov_t e, o;
    int i = 0;
    drv(0, 0, 0, 0, 0, 0, 1, 32'h500, 0);
    exp_q.push_back(ev(0, 0, 1, 1, 1, 1, 0));
    repeat (7) begin
      idle(); exp_q.push_back(ev(0, 0, 1, 0, 1, 1, 0));
    end
    idle(); exp_q.push_back(ev(1, 32'h500, 1, 0, 0, 1, 1));
    idle(); exp_q.push_back(ev(0, 0, 1, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL timeout[%0d]: got %h expected %h", i, o, e);
      end
      i++;
    end
  endtask

  task automatic test_reset_mid_flush();
    ov_t e, o;
    int i = 0;
    drv(0, 0, 0, 0, 0, 0, 1, 32'h200, 0);
    exp_q.push_back(ev(0, 0, 1, 1, 1, 1, 0));
    idle(); exp_q.push_back(ev(0, 0, 1, 0, 1, 1, 0));
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_q.push_back(ev(0, 0, 3, 0, 0, 0, 0));
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
    exp_q.push_back(ev(0, 0, 3, 0, 0, 0, 0));
    idle(); exp_q.push_back(ev(0, 0, 3, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_mid_flush[%0d]: got %h expected %h", i, o, e);
      end
      i++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    cur_priv = 2'd1;
    rst = 1'b1; exc = 0; exc_pc = 0; exc_priv = 0;
    mis = 0; mis_pc = 0; fen = 0; fen_pc = 0; done = 0;
    test_reset();
    test_simultaneous();
    test_fencei();
    test_exc_in_flush();
    test_back_to_back();
    test_timeout();
    test_reset_mid_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/biriscv_fetch_redirect_ctrl.md
Name: biriscv_fetch_redirect_ctrl

Overview:
Sequences all front-end redirects into the fetch unit's single branch/invalidate/hold interface. Sources are exception/trap redirects, branch mispredicts and FENCE.I. Arbitrates the three sources by fixed priority, runs the FENCE.I flush sequence (invalidate, hold fetch, wait for the I-cache flush to complete, then redirect), and guarantees at most one redirect pulse per cycle. Sits between the issue/exec/CSR stages and the fetch stage.

Parameters:
FLUSH_TIMEOUT, 255, max cycles spent in WAIT_FLUSH before forcing completion; range 1..65535.
TIMEOUT_W, 16, width of the timeout counter; must satisfy FLUSH_TIMEOUT < 2^TIMEOUT_W.

Ports:
clk_i  in  1  clock; all logic rises on posedge.
rst_i  in  1  reset, synchronous, active-high.
exc_redirect_i  in  1  trap/xRET redirect request, one-cycle pulse.
exc_pc_i  in  32  exception target PC.
exc_priv_i  in  2  privilege level after the trap.
mispred_i  in  1  branch mispredict redirect, one-cycle pulse.
mispred_pc_i  in  32  corrected PC.
fencei_i  in  1  FENCE.I retired, one-cycle pulse.
fencei_pc_i  in  32  PC following the FENCE.I.
cur_priv_i  in  2  current privilege; used for mispredict and FENCE.I redirects.
icache_flush_done_i  in  1  I-cache reports its invalidate sweep is complete.
branch_request_o  out  1  redirect pulse to fetch.
branch_pc_o  out  32  redirect PC; valid only with branch_request_o, otherwise 0.
branch_priv_o  out  2  redirect privilege.
fetch_invalidate_o  out  1  I-cache invalidate pulse to fetch.
hold_flag_o  out  1  stalls fetch PC advance.
busy_o  out  1  FSM is not in IDLE.
flush_timeout_o  out  1  one-cycle pulse when a flush is force-completed.

Behaviour:
- All outputs are registered. Reset values: all outputs 0; branch_priv_o = PRIV_MACHINE; state = IDLE.
- Reset is synchronous. Asserting rst_i mid-flush returns to IDLE next edge, drops any pending target, and deasserts hold.
- FSM states: IDLE, WAIT_FLUSH, REDIRECT.
- IDLE arbitration uses fixed priority: exc > mispred > fencei. Losing requests in the same cycle are discarded, because they belong to squashed younger instructions.
  - exc or mispred at edge N: branch_request_o=1 for exactly one cycle at N+1, with the selected PC and priv. Stay in IDLE.
  - fencei only at edge N: fetch_invalidate_o pulses at N+1. hold_flag_o=1 from N+1. pend_pc=fencei_pc_i, pend_priv=cur_priv_i. Go to WAIT_FLUSH; timeout counter cleared.
- WAIT_FLUSH:
  - hold_flag_o=1; counter increments each cycle.
  - exc_redirect_i overwrites pend_pc/pend_priv with the exception target. The last exception wins.
  - mispred_i and fencei_i are ignored.
  - icache_flush_done_i, or counter==FLUSH_TIMEOUT-1, moves to REDIRECT. On timeout, flush_timeout_o pulses in the same cycle the state changes.
  - done and exc in the same cycle: the exception target is captured and used.
- REDIRECT: branch_request_o=1 with pend_pc/pend_priv for one cycle. hold_flag_o=0 in that cycle. Return to IDLE. Requests arriving in this cycle are arbitrated as in IDLE.
- Total FENCE.I latency: done seen at edge M -> redirect at M+1; hold drops at M+1.
- branch_pc_o[1:0] is passed through unmodified; alignment is the producer's responsibility.

Optional Feature:
BIRISCV_REDIRECT_STATS_EN
- Defined: adds three saturating 32-bit counters (stat_exc_o, stat_mispred_o, stat_fencei_o), each incremented when its source wins arbitration or, for FENCE.I, when it completes. Counters clear on rst_i and saturate at 0xFFFFFFFF.
- Undefined: counters and ports are absent; other behaviour is identical.

Decomposition:
- Shared package/defines file: PRIV_MACHINE/PRIV_SUPER/PRIV_USER, the FSM state encodings (2-bit), and the redirect-source priority enum.
- One sub-module: biriscv_redirect_arb, a purely combinational 3-input fixed-priority select producing a winner one-hot plus PC/priv. It is reused by the top FSM in IDLE and REDIRECT.

Test Plan:
1. Reset: hold rst_i 3 cycles with requests active -> all outputs 0, branch_priv_o=3, busy_o=0.
2. Simultaneous: exc_redirect_i(pc 0x8000_0100, priv 3) + mispred_i(0x1234) + fencei_i at N -> N+1 branch_request_o=1, pc 0x8000_0100, priv 3. No invalidate; busy_o stays 0.
3. FENCE.I: fencei_i pc 0x200 at N; done at N+5 -> invalidate pulse N+1; hold N+1..N+5; branch_request_o pc 0x200 at N+6; hold=0 at N+6.
4. Exception during flush: fencei 0x200; exc 0x8000_0004 priv 3 at N+2; mispred at N+3; done N+4 -> redirect at N+5 to 0x8000_0004 priv 3. Mispredict produces no pulse.
5. Timeout with FLUSH_TIMEOUT=8 and no done -> flush_timeout_o pulse and entry to REDIRECT after 8 WAIT_FLUSH cycles; redirect to fencei_pc the cycle after.
6. Reset mid-WAIT_FLUSH, then done arrives -> no redirect issued, hold 0, state IDLE.
